// File: rtl/btn_pkg.sv
// Shared definitions for the push-button processing chain: FSM state
// encoding, default board timing and small arithmetic helpers.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      HOLD   = 2'b01,
      REPEAT = 2'b10
   } state_t;

   // 50 MHz board: 500 ms initial delay, 100 ms repeat period
   localparam int DEF_DELAY_CYC = 25_000_000;
   localparam int DEF_RATE_CYC  = 5_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // 8-bit increment that sticks at all-ones
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'd255) ? 8'd255 : v + 8'd1;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// Reloadable down-counter with a registered zero flag. The flag always
// mirrors (count == 0) so the owner can test expiry without a compare path.
module tick_timer #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          en,
   output logic          zero
);

   logic [CW-1:0] cnt_r;

   // count register and its zero flag; load beats enable, count stops at zero
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= '0;
         zero  <= 1'b1;
      end else if (load) begin
         cnt_r <= load_val;
         zero  <= (load_val == '0);
      end else if (en && !zero) begin
         cnt_r <= cnt_r - CW'(1);
         zero  <= (cnt_r == CW'(1));
      end
   end

endmodule

// File: rtl/key_repeat.sv
// Typematic stage behind the debouncer: press tick, auto-repeat ticks after
// an initial delay, release tick, hold flags and a saturating repeat count.
module key_repeat
   import btn_pkg::*;
#(
   parameter int DELAY_CYC = DEF_DELAY_CYC,
   parameter int RATE_CYC  = DEF_RATE_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       db_level,
   input  logic       db_tick,
   output logic       key_tick,
   output logic       rep_tick,
   output logic       rel_tick,
   output logic       held,
   output logic       long_hold,
   output logic [7:0] rep_cnt
);

   localparam int CW = $clog2(max_int(DELAY_CYC, RATE_CYC));
   localparam logic [CW-1:0] DELAY_LD = CW'(DELAY_CYC - 1);
   localparam logic [CW-1:0] RATE_LD  = CW'(RATE_CYC - 1);

   state_t        state_r;
   state_t        state_nx_s;
   logic          key_nx_s;
   logic          rep_nx_s;
   logic          rel_nx_s;
   logic          held_nx_s;
   logic          long_nx_s;
   logic [7:0]    cnt_nx_s;
   logic          tmr_load_s;
   logic [CW-1:0] tmr_val_s;
   logic          tmr_en_s;
   logic          tmr_zero_s;

   tick_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .en       (tmr_en_s),
      .zero     (tmr_zero_s)
   );

   // next-state, timer control and next output values
   always_comb begin
      state_nx_s = state_r;
      key_nx_s   = 1'b0;
      rep_nx_s   = 1'b0;
      rel_nx_s   = 1'b0;
      cnt_nx_s   = rep_cnt;
      tmr_load_s = 1'b0;
      tmr_val_s  = '0;
      tmr_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            // db_level is ignored here: only a fresh debounced press starts
            if (db_tick) begin
               state_nx_s = HOLD;
               tmr_load_s = 1'b1;
               tmr_val_s  = DELAY_LD;
               key_nx_s   = 1'b1;
               cnt_nx_s   = 8'd0;
            end else begin
               state_nx_s = IDLE;
            end
         end
         HOLD, REPEAT: begin
            // release has priority over a coinciding expiry; db_tick ignored
            if (!db_level) begin
               state_nx_s = IDLE;
               rel_nx_s   = 1'b1;
               tmr_load_s = 1'b1;
               tmr_val_s  = '0;
            end else if (tmr_zero_s) begin
               state_nx_s = REPEAT;
               tmr_load_s = 1'b1;
               tmr_val_s  = RATE_LD;
               rep_nx_s   = 1'b1;
               cnt_nx_s   = sat_inc8(rep_cnt);
            end else begin
               tmr_en_s   = 1'b1;
            end
         end
         default: begin
            // unreachable encoding: park in IDLE with everything cleared
            state_nx_s = IDLE;
            tmr_load_s = 1'b1;
            tmr_val_s  = '0;
            cnt_nx_s   = 8'd0;
         end
      endcase
      held_nx_s = (state_nx_s == HOLD) || (state_nx_s == REPEAT);
      long_nx_s = (state_nx_s == REPEAT);
   end

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         key_tick  <= 1'b0;
         rep_tick  <= 1'b0;
         rel_tick  <= 1'b0;
         held      <= 1'b0;
         long_hold <= 1'b0;
         rep_cnt   <= 8'd0;
      end else begin
         state_r   <= state_nx_s;
         key_tick  <= key_nx_s;
         rep_tick  <= rep_nx_s;
         rel_tick  <= rel_nx_s;
         held      <= held_nx_s;
         long_hold <= long_nx_s;
         rep_cnt   <= cnt_nx_s;
      end
   end

endmodule

// File: tb/tb_key_repeat.sv
// Scoreboard bench for key_repeat. dut_a uses DELAY=8/RATE=3, dut_b uses
// DELAY=8/RATE=1 for the saturation case. Stimulus pushes expected output
// snapshots keyed by cycle; a negedge monitor pops and compares them and
// flags any tick that appears in a cycle with no expectation.
module tb_key_repeat;

   typedef struct {
      int         cyc;
      logic       key;
      logic       rep;
      logic       rel;
      logic       held;
      logic       lng;
      logic [7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic [1:0] rst_in;
   logic [1:0] tick_in;
   logic [1:0] lvl_in;
   logic [1:0] key_o, rep_o, rel_o, held_o, long_o;
   logic [7:0] cnt_a, cnt_b;

   int   ecount = 0;
   int   chk_cnt = 0;
   int   pass_cnt = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   key_repeat #(.DELAY_CYC(8), .RATE_CYC(3)) dut_a (
      .clk(clk), .reset(rst_in[0]), .db_level(lvl_in[0]), .db_tick(tick_in[0]),
      .key_tick(key_o[0]), .rep_tick(rep_o[0]), .rel_tick(rel_o[0]),
      .held(held_o[0]), .long_hold(long_o[0]), .rep_cnt(cnt_a));

   key_repeat #(.DELAY_CYC(8), .RATE_CYC(1)) dut_b (
      .clk(clk), .reset(rst_in[1]), .db_level(lvl_in[1]), .db_tick(tick_in[1]),
      .key_tick(key_o[1]), .rep_tick(rep_o[1]), .rel_tick(rel_o[1]),
      .held(held_o[1]), .long_hold(long_o[1]), .rep_cnt(cnt_b));

   task automatic push(input int d, input int c, input logic k, input logic r,
                       input logic l, input logic h, input logic lg, input logic [7:0] n);
      exp_t e;
      e.cyc = c; e.key = k; e.rep = r; e.rel = l; e.held = h; e.lng = lg; e.cnt = n;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
   endtask

   task automatic mon(input int d, input logic k, input logic r, input logic l,
                      input logic h, input logic lg, input logic [7:0] n);
      exp_t e;
      bit   have;
      int   now;
      now  = ecount + 1;
      have = 1'b0;
      if (d == 0) begin
         if (qa.size() != 0 && qa[0].cyc <= now) begin e = qa.pop_front(); have = 1'b1; end
      end else begin
         if (qb.size() != 0 && qb[0].cyc <= now) begin e = qb.pop_front(); have = 1'b1; end
      end
      if (have) begin
         chk_cnt++;
         if (e.cyc != now || k !== e.key || r !== e.rep || l !== e.rel ||
             h !== e.held || lg !== e.lng || n !== e.cnt) begin
            $display("FAIL dut%0d cycle %0d: got key=%b rep=%b rel=%b held=%b long=%b cnt=%0d, want key=%b rep=%b rel=%b held=%b long=%b cnt=%0d (for cycle %0d)",
                     d, now, k, r, l, h, lg, n, e.key, e.rep, e.rel, e.held, e.lng, e.cnt, e.cyc);
         end else begin
            pass_cnt++;
         end
      end else if (k === 1'b1 || r === 1'b1 || l === 1'b1) begin
         chk_cnt++;
         $display("FAIL dut%0d cycle %0d: unexpected tick key=%b rep=%b rel=%b, want none",
                  d, now, k, r, l);
      end
   endtask

   // monitor: compare both DUTs once per cycle, away from the active edge
   always @(negedge clk) begin
      mon(0, key_o[0], rep_o[0], rel_o[0], held_o[0], long_o[0], cnt_a);
      mon(1, key_o[1], rep_o[1], rel_o[1], held_o[1], long_o[1], cnt_b);
   end

   // relative edge 10 carries db_tick (plus optional tick2); db_level is high
   // on relative edges 11..off-1; reset on relative edge rst
   task automatic drive(input int d, input int base, input int len, input int off,
                        input int tick2, input int rst);
      for (int k = 1; k <= len; k++) begin
         tick_in[d] = (k == 10) || (k == tick2);
         lvl_in[d]  = (k >= 11) && (k < off);
         rst_in[d]  = (k == rst);
         @(negedge clk);
      end
      tick_in[d] = 1'b0;
      lvl_in[d]  = 1'b0;
      rst_in[d]  = 1'b0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   initial begin
      int base;
      rst_in  = 2'b11;
      tick_in = 2'b00;
      lvl_in  = 2'b00;
      // reset state
      push(0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      push(1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      repeat (3) @(negedge clk);
      rst_in = 2'b00;

      // short press, release at edge 15
      base = ecount;
      push(0, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 16, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      push(0, base + 17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      drive(0, base, 20, 15, 0, 0);

      // long hold, release at edge 26
      base = ecount;
      push(0, base + 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      push(0, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
      push(0, base + 22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
      push(0, base + 25, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3);
      push(0, base + 26, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3);
      push(0, base + 27, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
      push(0, base + 28, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      drive(0, base, 30, 26, 0, 0);

      // release on the expiry edge 18: release wins
      base = ecount;
      push(0, base + 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      push(0, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 19, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      push(0, base + 20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      drive(0, base, 22, 18, 0, 0);

      // spurious db_tick at edge 14 while in HOLD, release at edge 20
      base = ecount;
      push(0, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
      push(0, base + 20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
      push(0, base + 21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
      drive(0, base, 24, 20, 14, 0);

      // reset at edge 20 mid-REPEAT, button held until edge 40
      base = ecount;
      push(0, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(0, base + 19, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
      push(0, base + 20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
      push(0, base + 21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      push(0, base + 30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      push(0, base + 40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      push(0, base + 42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      drive(0, base, 45, 40, 0, 20);

      // RATE_CYC = 1: repeat every cycle, counter saturates at 255
      base = ecount;
      push(1, base + 11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      push(1, base + 18, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int c = 19; c <= 319; c++) begin
         push(1, base + c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
              ((c - 18) > 255) ? 8'd255 : 8'(c - 18));
      end
      push(1, base + 320, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255);
      push(1, base + 321, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);
      drive(1, base, 325, 319, 0, 0);

      repeat (3) @(negedge clk);
      chk_cnt++;
      if (qa.size() != 0 || qb.size() != 0) begin
         $display("FAIL leftover: got %0d/%0d unconsumed expectations, want 0/0",
                  qa.size(), qb.size());
      end else begin
         pass_cnt++;
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
